level_tracker: RTL and testbench

//  Upstream of the fall timer. Counts cleared lines, advances the game level every

---
 rtl/level_tracker.sv | 107 ++++++++++
 tb/tb_level_tracker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/level_tracker.sv
`default_nettype none
// ============================================================================
// Module      : level_tracker
// Description : Counts cleared lines, steps the game level every
//               LINES_PER_LEVEL lines (saturating), and accumulates the score.
// Revision    : 1.0 - initial release
// ============================================================================
module level_tracker #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int START_LEVEL     = 0,
  parameter int MAX_LEVEL       = 14,
  parameter int SCORE_MAX       = 999_999,
  parameter int LINES_MAX       = 9_999,
  parameter int LEVEL_LEN       = $clog2(MAX_LEVEL + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 freeze,
  input  logic                 clear_valid,
  input  logic [2:0]           clear_cnt,
  output logic [LEVEL_LEN-1:0] level,
  output logic                 level_up,
  output logic [13:0]          lines,
  output logic [19:0]          score
);

  localparam int c_TN_W  = $clog2(LINES_PER_LEVEL + 1);
  localparam int c_TW    = c_TN_W + 1;
  localparam int c_MUL_W = LEVEL_LEN + 1;
  localparam int c_ADD_W = 11 + c_MUL_W;

  logic [c_TN_W-1:0]  r_to_next;

  logic               w_accept;
  logic [10:0]        w_base;
  logic [c_MUL_W-1:0] w_mult;
  logic [c_ADD_W-1:0] w_add;
  logic [20:0]        w_score_sum;
  logic [19:0]        w_score_next;
  logic [14:0]        w_lines_sum;
  logic [13:0]        w_lines_next;
  logic [c_TN_W-1:0]  w_k_tn;
  logic               w_cross;
  logic [c_TW-1:0]    w_tn_wrap;
  logic [c_TN_W-1:0]  w_tn_next;
  logic               w_at_max;

  assign w_accept = clear_valid & ~freeze & ~start &
                    (clear_cnt >= 3'd1) & (clear_cnt <= 3'd4);

  always_comb begin
    w_base = 11'd0;
    case (clear_cnt)
      3'd1:    w_base = 11'd40;
      3'd2:    w_base = 11'd100;
      3'd3:    w_base = 11'd300;
      3'd4:    w_base = 11'd1200;
      default: w_base = 11'd0;
    endcase
  end

  // Multiplier is the pre-increment level plus one.
  assign w_mult       = c_MUL_W'(level) + c_MUL_W'(1);
  assign w_add        = c_ADD_W'(w_base) * c_ADD_W'(w_mult);
  assign w_score_sum  = {1'b0, score} + 21'(w_add);
  assign w_score_next = (w_score_sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : w_score_sum[19:0];

  assign w_lines_sum  = {1'b0, lines} + 15'(clear_cnt);
  assign w_lines_next = (w_lines_sum > 15'(LINES_MAX)) ? 14'(LINES_MAX) : w_lines_sum[13:0];

  assign w_k_tn    = c_TN_W'(clear_cnt);
  assign w_cross   = (w_k_tn >= r_to_next);
  // Wrap computed one bit wider; the result always fits back into c_TN_W.
  assign w_tn_wrap = c_TW'(r_to_next) + c_TW'(LINES_PER_LEVEL) - c_TW'(clear_cnt);
  assign w_tn_next = w_cross ? w_tn_wrap[c_TN_W-1:0] : (r_to_next - w_k_tn);
  assign w_at_max  = (level == LEVEL_LEN'(MAX_LEVEL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= LEVEL_LEN'(START_LEVEL);
      level_up  <= 1'b0;
      lines     <= 14'd0;
      score     <= 20'd0;
      r_to_next <= c_TN_W'(LINES_PER_LEVEL);
    end else if (start) begin
      level     <= LEVEL_LEN'(START_LEVEL);
      level_up  <= 1'b0;
      lines     <= 14'd0;
      score     <= 20'd0;
      r_to_next <= c_TN_W'(LINES_PER_LEVEL);
    end else begin
      level_up <= 1'b0;
      if (w_accept) begin
        score     <= w_score_next;
        lines     <= w_lines_next;
        r_to_next <= w_tn_next;
        if (w_cross && !w_at_max) begin
          level    <= level + LEVEL_LEN'(1);
          level_up <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_level_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_tracker
// Description : Randomized and directed scoreboard bench for level_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_tracker;

  localparam int LPL   = 10;
  localparam int START = 0;
  localparam int MAXL  = 14;
  localparam int SMAX  = 999_999;
  localparam int LMAX  = 9_999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        freeze = 1'b0;
  logic        clear_valid = 1'b0;
  logic [2:0]  clear_cnt = 3'd0;
  logic [3:0]  level;
  logic        level_up;
  logic [13:0] lines;
  logic [19:0] score;

  level_tracker #(
    .LINES_PER_LEVEL(LPL), .START_LEVEL(START), .MAX_LEVEL(MAXL),
    .SCORE_MAX(SMAX), .LINES_MAX(LMAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .freeze(freeze),
    .clear_valid(clear_valid), .clear_cnt(clear_cnt),
    .level(level), .level_up(level_up), .lines(lines), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    bit up;
    int lns;
    int scr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: level derived from the unsaturated running line total.
  int m_total, m_lines, m_score, m_level;
  bit m_up;

  function automatic int base_of(int k);
    case (k)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_total = 0; m_lines = 0; m_score = 0; m_level = START; m_up = 0;
  endtask

  task automatic model_step(bit st, bit fr, bit cv, int k);
    int nl;
    m_up = 0;
    if (st) begin
      model_reset();
    end else if (cv && !fr && k >= 1 && k <= 4) begin
      m_score = m_score + base_of(k) * (m_level + 1);
      if (m_score > SMAX) m_score = SMAX;
      m_lines = m_lines + k;
      if (m_lines > LMAX) m_lines = LMAX;
      m_total = m_total + k;
      nl = START + m_total / LPL;
      if (nl > MAXL) nl = MAXL;
      m_up  = (nl != m_level);
      m_level = nl;
    end
  endtask

  task automatic cyc(bit st, bit fr, bit cv, int k);
    exp_t e;
    @(negedge clk);
    start = st; freeze = fr; clear_valid = cv; clear_cnt = 3'(k);
    model_step(st, fr, cv, k);
    e.lvl = m_level; e.up = m_up; e.lns = m_lines; e.scr = m_score;
    q.push_back(e);
  endtask

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("level",    int'(level),    e.lvl);
        chk("level_up", int'(level_up), int'(e.up));
        chk("lines",    int'(lines),    e.lns);
        chk("score",    int'(score),    e.scr);
      end
    end
  end

  initial begin : driver
    int wait_cnt;
    model_reset();
    #1;
    chk("rst_level", int'(level), START);
    chk("rst_score", int'(score), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Four events at level 0, the last crossing into level 1.
    for (int k = 1; k <= 4; k++) cyc(0, 0, 1, k);
    cyc(0, 0, 0, 0);

    // Straddle: 8 lines, then k=4 crosses with the level-0 multiplier, then k=1.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 4); cyc(0, 0, 1, 4);
    cyc(0, 0, 1, 4); cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);

    // Simultaneous start and clear: start wins.
    cyc(1, 0, 1, 4);
    cyc(0, 0, 0, 0);

    // Ignored inputs: frozen clears, then illegal counts.
    cyc(0, 0, 1, 3);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1 + (i % 4));
    for (int i = 0; i < 21; i++) cyc(0, 0, 1, (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 5 : 7));

    // Saturation: reach level 14, keep clearing until the score pins.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, 4);
    cyc(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)));

    // Asynchronous reset from level 3, no clock edge needed.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 4);
    cyc(0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("pre_rst_level", int'(level), 3);
    rst = 1'b1;
    #1;
    chk("async_rst_level",    int'(level),    START);
    chk("async_rst_level_up", int'(level_up), 0);
    chk("async_rst_lines",    int'(lines),    0);
    chk("async_rst_score",    int'(score),    0);
    model_reset();
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(0, 0, 1, 2);
    cyc(0, 0, 0, 0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
